// File: rtl/cirno9_mem_arb_pkg.sv
// Shared constants for the cirno9 memory-port arbiter.
// Arbitration mode selectors and the channel-count ceiling.
package cirno9_mem_arb_pkg;

    localparam int ARB_FIX       = 0;
    localparam int ARB_RR        = 1;
    localparam int MEM_ARB_MAXCH = 8;

endpackage

// File: rtl/cirno9_mem_arb_rr_arb.sv
// Rotating-priority request picker: first requester at or after ptr wins.
// Tying ptr to zero turns it into a plain lowest-index-first arbiter.
module cirno9_rr_arb
    import cirno9_mem_arb_pkg::*;
#(
    parameter int NCH = 3
) (
    input  logic [NCH-1:0]         req,
    input  logic [$clog2(NCH)-1:0] ptr,
    output logic [NCH-1:0]         grant,
    output logic [$clog2(NCH)-1:0] idx
);

    localparam int IW = $clog2(NCH);

    logic [IW:0] k;
    logic        hit;

    // Scan NCH slots starting at ptr, wrapping past the last channel.
    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        k     = '0;
        for (int i = 0; i < NCH; i++) begin
            k = {1'b0, ptr} + (IW+1)'(i);
            if (k >= (IW+1)'(NCH)) begin
                k = k - (IW+1)'(NCH);
            end
            if (!hit && req[k[IW-1:0]]) begin
                hit               = 1'b1;
                grant[k[IW-1:0]]  = 1'b1;
                idx               = k[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/cirno9_mem_arb.sv
// N-channel SRAM port arbiter with grant lock on stall and tagged read return.
// Request path is combinational; only lock, pointer and return tags are registered.
module cirno9_mem_arb
    import cirno9_mem_arb_pkg::*;
#(
    parameter int NCH      = 3,
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int RD_LAT   = 1,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH-1:0]        i_ch_val,
    output logic [NCH-1:0]        o_ch_rdy,
    input  logic [NCH*AW-1:0]     i_ch_adr,
    input  logic [NCH*DW-1:0]     i_ch_wdat,
    input  logic [NCH*DW/8-1:0]   i_ch_wen,
    input  logic [NCH-1:0]        i_ch_ren,
    output logic [NCH-1:0]        o_ch_rvld,
    output logic [DW-1:0]         o_rdat,
    output logic                  o_err,
    output logic                  o_sram_ren,
    output logic [DW/8-1:0]       o_sram_wen,
    output logic [AW-1:0]         o_adr,
    output logic [DW-1:0]         o_wdat,
    input  logic                  i_hs_ram4ls_rdy,
    input  logic [DW-1:0]         i_sram_rdat
);

    localparam int WW = DW / 8;
    localparam int IW = $clog2(NCH);

    logic [AW-1:0] ch_adr  [NCH];
    logic [DW-1:0] ch_wdat [NCH];
    logic [WW-1:0] ch_wen  [NCH];

    for (genvar c = 0; c < NCH; c++) begin : g_unpack
        assign ch_adr[c]  = i_ch_adr[c*AW +: AW];
        assign ch_wdat[c] = i_ch_wdat[c*DW +: DW];
        assign ch_wen[c]  = i_ch_wen[c*WW +: WW];
    end

    logic           lock_q;
    logic [IW-1:0]  lock_idx_q;
    logic [IW-1:0]  ptr_q;
    logic [IW-1:0]  arb_ptr;
    logic [NCH-1:0] arb_grant;
    logic [IW-1:0]  arb_idx;

    assign arb_ptr = (ARB_MODE == ARB_RR) ? ptr_q : '0;

    cirno9_rr_arb #(.NCH(NCH)) u_arb (
        .req   (i_ch_val),
        .ptr   (arb_ptr),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    logic [IW-1:0]  gnt_idx;
    logic [NCH-1:0] gnt_vec;
    logic           gnt_vld;
    logic           accept;
    logic           g_ren;
    logic [WW-1:0]  g_wen;
    logic           illegal;

    // A stalled request keeps its grant so the SRAM sees a stable payload.
    always_comb begin
        gnt_vec = arb_grant;
        gnt_idx = arb_idx;
        if (lock_q) begin
            gnt_vec             = '0;
            gnt_vec[lock_idx_q] = 1'b1;
            gnt_idx             = lock_idx_q;
        end
    end

    assign gnt_vld = rst_n & i_ch_val[gnt_idx];
    assign accept  = gnt_vld & i_hs_ram4ls_rdy;
    assign g_ren   = i_ch_ren[gnt_idx];
    assign g_wen   = ch_wen[gnt_idx];
    assign illegal = g_ren & (|g_wen);

    assign o_ch_rdy   = accept ? gnt_vec : '0;
    assign o_sram_ren = gnt_vld & g_ren & ~illegal;
    assign o_sram_wen = gnt_vld ? g_wen : '0;
    assign o_adr      = gnt_vld ? ch_adr[gnt_idx] : '0;
    assign o_wdat     = gnt_vld ? ch_wdat[gnt_idx] : '0;
    assign o_err      = accept & illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            ptr_q      <= '0;
        end else begin
            if (gnt_vld && !i_hs_ram4ls_rdy) begin
                lock_q     <= 1'b1;
                lock_idx_q <= gnt_idx;
            end else if (accept) begin
                lock_q <= 1'b0;
            end
            if (accept) begin
                ptr_q <= (gnt_idx == IW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

    logic [RD_LAT-1:0] pipe_vld;
    logic [IW-1:0]     pipe_ch [RD_LAT];

    // Tag pipe mirrors SRAM read latency; illegal requests never enter it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_ch[i] <= '0;
            end
        end else begin
            pipe_vld[0] <= accept & g_ren & ~illegal;
            pipe_ch[0]  <= gnt_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_ch[i]  <= pipe_ch[i-1];
            end
        end
    end

    always_comb begin
        o_ch_rvld = '0;
        if (pipe_vld[RD_LAT-1]) begin
            o_ch_rvld[pipe_ch[RD_LAT-1]] = 1'b1;
        end
    end

    assign o_rdat = pipe_vld[RD_LAT-1] ? i_sram_rdat : '0;

endmodule
